// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one instruction-memory request at a time,
// and presents each returned word with its PC to decode over valid/ready.
//
// state | meaning
// BOOT  | first cycle out of reset, no request yet
// REQ   | request presented at pc, waiting for memory to accept it
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to decode, waiting for inst_ready
// DRAIN | accepted request was killed by a redirect, swallowing its response
module fetch_ctrl #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_vec,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [31:0]       inst_data,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] fetch_pc
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [31:0]       inst_data_q;
    logic              capture;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    // Trap has priority over a branch redirect; targets are forced word-aligned.
    assign redirect = trap_valid | redirect_valid;
    assign target   = (trap_valid ? trap_vec : redirect_pc) & ~ADDR_W'(3);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = REQ;
                if (redirect) pc_d = target;
            end
            REQ: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_req_ready ? DRAIN : REQ;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_rsp_valid ? REQ : DRAIN;
                end else if (imem_rsp_valid) begin
                    capture = 1'b1;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (inst_ready) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                // A response arriving with a redirect still completes the drain.
                if (redirect) pc_d = target;
                if (imem_rsp_valid) state_d = REQ;
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            inst_pc_q   <= '0;
            inst_data_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                inst_pc_q   <= pc_q;
                inst_data_q <= imem_rsp_data;
            end
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign fetch_pc       = pc_q;
    assign inst_valid     = (state_q == HOLD);
    assign inst_pc        = inst_pc_q;
    assign inst_data      = inst_data_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus a hand-written
// async-reset-mid-fetch sequence.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic [31:0] fetch_pc;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready),
        .fetch_pc       (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        tv;
        logic [31:0] tvec;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        irdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_idata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic tv, logic [31:0] tvec,
                                logic rdy, logic rspv, logic [31:0] rspd, logic irdy,
                                logic e_req, logic [31:0] e_addr, logic e_iv,
                                logic [31:0] e_ipc, logic [31:0] e_idata);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.tv = tv; v.tvec = tvec;
        v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.irdy = irdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_ipc = e_ipc; v.e_idata = e_idata;
        return v;
    endfunction

    task automatic check(string name, logic e_req, logic [31:0] e_addr, logic e_iv,
                         logic [31:0] e_ipc, logic [31:0] e_idata);
        total++;
        if (imem_req_valid !== e_req || imem_req_addr !== e_addr || fetch_pc !== e_addr ||
            inst_valid !== e_iv || inst_pc !== e_ipc || inst_data !== e_idata) begin
            bad++;
            $display("FAIL %s: got req=%0b addr=%h fpc=%h iv=%0b ipc=%h idata=%h want req=%0b addr=%h iv=%0b ipc=%h idata=%h",
                     name, imem_req_valid, imem_req_addr, fetch_pc, inst_valid, inst_pc, inst_data,
                     e_req, e_addr, e_iv, e_ipc, e_idata);
        end
    endtask

    task automatic drive(logic rv, logic [31:0] rpc, logic tv, logic [31:0] tvec,
                         logic rdy, logic rspv, logic [31:0] rspd, logic irdy);
        redirect_valid = rv;  redirect_pc   = rpc;
        trap_valid     = tv;  trap_vec      = tvec;
        imem_req_ready = rdy; imem_rsp_valid = rspv;
        imem_rsp_data  = rspd; inst_ready   = irdy;
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        // redirect, trap, mem, decode inputs  ->  expected req/addr, inst_valid/pc/data
        // sequential fetch
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            0,32'h80000000, 0,32'h00000000,32'h00000000)); // 0 BOOT
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h80000000, 0,32'h00000000,32'h00000000)); // 1 REQ
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'hAAAA0001,0, 0,32'h80000000, 0,32'h00000000,32'h00000000)); // 2 WAIT
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,1,            0,32'h80000004, 1,32'h80000000,32'hAAAA0001)); // 3 HOLD
        // memory backpressure at 0x80000004
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            1,32'h80000004, 0,32'h80000000,32'hAAAA0001));
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            1,32'h80000004, 0,32'h80000000,32'hAAAA0001));
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            1,32'h80000004, 0,32'h80000000,32'hAAAA0001));
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h80000004, 0,32'h80000000,32'hAAAA0001)); // 7
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'h00000013,0, 0,32'h80000004, 0,32'h80000000,32'hAAAA0001)); // 8 WAIT
        // decode backpressure for 4 cycles
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            0,32'h80000008, 1,32'h80000004,32'h00000013));
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            0,32'h80000008, 1,32'h80000004,32'h00000013));
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            0,32'h80000008, 1,32'h80000004,32'h00000013));
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            0,32'h80000008, 1,32'h80000004,32'h00000013));
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,1,            0,32'h80000008, 1,32'h80000004,32'h00000013)); // 13
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h80000008, 0,32'h80000004,32'h00000013)); // 14 REQ
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'hAAAA0003,0, 0,32'h80000008, 0,32'h80000004,32'h00000013)); // 15 WAIT
        // stray response in HOLD must be ignored
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'hDEAD0000,1, 0,32'h8000000C, 1,32'h80000008,32'hAAAA0003)); // 16 HOLD
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h8000000C, 0,32'h80000008,32'hAAAA0003)); // 17 REQ
        // redirect while in flight, misaligned target, response two cycles later
        vecs.push_back(mk(1,32'h80000102,0,Z, 0,0,Z,0, 0,32'h8000000C, 0,32'h80000008,32'hAAAA0003)); // 18 WAIT
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,0,            0,32'h80000100, 0,32'h80000008,32'hAAAA0003)); // 19 DRAIN
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'hBAD0BAD0,0, 0,32'h80000100, 0,32'h80000008,32'hAAAA0003)); // 20 DRAIN
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h80000100, 0,32'h80000008,32'hAAAA0003)); // 21 REQ
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'hAAAA0100,0, 0,32'h80000100, 0,32'h80000008,32'hAAAA0003)); // 22 WAIT
        // trap and redirect together in HOLD: trap wins, instruction dropped
        vecs.push_back(mk(1,32'h80000200,1,32'h80000400, 0,0,Z,0, 0,32'h80000104, 1,32'h80000100,32'hAAAA0100)); // 23
        // redirect in REQ without handshake, then wrap of pc+4
        vecs.push_back(mk(1,32'hFFFFFFFE,0,Z, 0,0,Z,0, 1,32'h80000400, 0,32'h80000100,32'hAAAA0100)); // 24 REQ
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'hFFFFFFFC, 0,32'h80000100,32'hAAAA0100)); // 25 REQ
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'hCCCC0001,0, 0,32'hFFFFFFFC, 0,32'h80000100,32'hAAAA0100)); // 26 WAIT
        vecs.push_back(mk(0,Z,0,Z, 0,0,Z,1,            0,32'h00000000, 1,32'hFFFFFFFC,32'hCCCC0001)); // 27 HOLD
        // redirect on the handshake cycle kills the accepted request
        vecs.push_back(mk(1,32'h80000800,0,Z, 1,0,Z,0, 1,32'h00000000, 0,32'hFFFFFFFC,32'hCCCC0001)); // 28 REQ
        vecs.push_back(mk(1,32'h80000900,0,Z, 0,0,Z,0, 0,32'h80000800, 0,32'hFFFFFFFC,32'hCCCC0001)); // 29 DRAIN
        vecs.push_back(mk(0,Z,0,Z, 0,1,32'h11111111,0, 0,32'h80000900, 0,32'hFFFFFFFC,32'hCCCC0001)); // 30 DRAIN
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h80000900, 0,32'hFFFFFFFC,32'hCCCC0001)); // 31 REQ
        // redirect coinciding with the response in WAIT
        vecs.push_back(mk(1,32'h80000A00,0,Z, 0,1,32'hEEEE0000,0, 0,32'h80000900, 0,32'hFFFFFFFC,32'hCCCC0001)); // 32
        vecs.push_back(mk(0,Z,0,Z, 1,0,Z,0,            1,32'h80000A00, 0,32'hFFFFFFFC,32'hCCCC0001)); // 33 REQ

        rst = 1'b1;
        drive(0, Z, 0, Z, 0, 0, Z, 0);
        repeat (2) @(negedge clk);
        check("reset_hold", 0, 32'h80000000, 0, Z, Z);
        rst = 1'b0;

        foreach (vecs[i]) begin
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                  vecs[i].e_ipc, vecs[i].e_idata);
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].tv, vecs[i].tvec,
                  vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].irdy);
            @(negedge clk);
        end

        // now in WAIT at 0x80000A00: async reset aborts the outstanding fetch
        drive(0, Z, 0, Z, 0, 0, Z, 0);
        check("wait_before_rst", 0, 32'h80000A00, 0, 32'hFFFFFFFC, 32'hCCCC0001);
        rst = 1'b1;
        #1;
        check("rst_async", 0, 32'h80000000, 0, Z, Z);
        @(negedge clk);
        rst = 1'b0;
        drive(0, Z, 0, Z, 0, 1, 32'hDEADBEEF, 0);
        check("boot_after_rst", 0, 32'h80000000, 0, Z, Z);
        @(negedge clk);
        drive(0, Z, 0, Z, 1, 0, Z, 0);
        check("late_rsp_ignored", 1, 32'h80000000, 0, Z, Z);
        @(negedge clk);
        drive(0, Z, 0, Z, 0, 0, Z, 0);
        check("post_rst_wait", 0, 32'h80000000, 0, Z, Z);
        @(negedge clk);
        drive(0, Z, 0, Z, 0, 1, 32'h12345678, 0);
        check("post_rst_wait2", 0, 32'h80000000, 0, Z, Z);
        @(negedge clk);
        drive(0, Z, 0, Z, 0, 0, Z, 0);
        check("post_rst_hold", 0, 32'h80000004, 1, 32'h80000000, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
